// File: rtl/instr_assembler_if.sv
// Request channel into the instruction assembler: handshake plus the
// field-level description of one instruction.
interface instr_assembler_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] imm_value;
   logic [2:0]  imm_src;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;

   // Instruction source side
   modport master (
      output in_valid, imm_value, imm_src, opcode, rd, rs1, rs2, funct3, funct7,
      input  in_ready
   );

   // Assembler side
   modport slave (
      input  in_valid, imm_value, imm_src, opcode, rd, rs1, rs2, funct3, funct7,
      output in_ready
   );
endinterface

// File: rtl/instr_assembler.sv
// Streaming RISC-V instruction assembler: range-checks the immediate for the
// selected format, packs it into architectural bit positions and writes the
// encoded word to instruction memory at an auto-incrementing address.
// imm_src: 0=U 1=J 2=S 3=B 4=I-signed 5=I-shift 6=I-unsigned 7=illegal.
module instr_assembler #(
   parameter int ADDR_W = 8,
   parameter int SIZE   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   instr_assembler_if.slave  req,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [SIZE-1:0]   wr_data,
   output logic              err_valid,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   count,
   output logic              full
);

   typedef enum logic {ACTIVE, FULL_ST} state_t;

   localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] ptr_reg;
   logic [ADDR_W:0]   count_reg;
   logic              wr_en_reg, err_valid_reg;
   logic [ADDR_W-1:0] wr_addr_reg;
   logic [SIZE-1:0]   wr_data_reg;
   logic [1:0]        err_code_reg;

   logic [31:0] imm;
   logic [31:0] enc_word;
   logic        range_err, align_err, illegal_err;
   logic [1:0]  err_sel;
   logic        accept;

   assign imm    = req.imm_value;
   assign accept = req.in_valid && req.in_ready;

   // Per-format range check and bit packing of the immediate
   always_comb begin
      range_err   = 1'b0;
      illegal_err = 1'b0;
      enc_word    = '0;
      case (req.imm_src)
         3'd0: begin
            range_err = (imm[11:0] != 12'd0);
            enc_word  = {imm[31:12], req.rd, req.opcode};
         end
         3'd1: begin
            range_err = (imm[31:20] != {12{imm[20]}});
            enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
         end
         3'd2: begin
            range_err = (imm[31:11] != {21{imm[11]}});
            enc_word  = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
         end
         3'd3: begin
            range_err = (imm[31:12] != {20{imm[12]}});
            enc_word  = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3,
                         imm[4:1], imm[11], req.opcode};
         end
         3'd4: begin
            range_err = (imm[31:11] != {21{imm[11]}});
            enc_word  = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
         end
         3'd5: begin
            range_err = (imm[31:5] != 27'd0);
            enc_word  = {req.funct7, imm[4:0], req.rs1, req.funct3, req.rd, req.opcode};
         end
         3'd6: begin
            range_err = (imm[31:12] != 20'd0);
            enc_word  = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
         end
         default: illegal_err = 1'b1;
      endcase
   end

   // Error priority: illegal format beats misalignment beats range
   always_comb begin
      align_err = ((req.imm_src == 3'd1) || (req.imm_src == 3'd3)) && imm[0];
      if (illegal_err)
         err_sel = 2'd3;
      else if (align_err)
         err_sel = 2'd2;
      else if (range_err)
         err_sel = 2'd1;
      else
         err_sel = 2'd0;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= ACTIVE;
      else
         state_reg <= state_next;
   end

   // FSM next state: the write filling the last slot enters FULL on its own edge
   always_comb begin
      state_next = state_reg;
      if (clear)
         state_next = ACTIVE;
      else if (accept && (err_sel == 2'd0) && (count_reg == LAST_CNT))
         state_next = FULL_ST;
   end

   // FSM outputs
   always_comb begin
      req.in_ready = (state_reg == ACTIVE) && !clear && !reset;
      full         = (state_reg == FULL_ST);
   end

   // Registered write/error stage and write pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg       <= '0;
         count_reg     <= '0;
         wr_en_reg     <= 1'b0;
         err_valid_reg <= 1'b0;
         wr_addr_reg   <= '0;
         wr_data_reg   <= '0;
         err_code_reg  <= 2'd0;
      end else begin
         wr_en_reg     <= 1'b0;
         err_valid_reg <= 1'b0;
         if (clear) begin
            ptr_reg     <= '0;
            count_reg   <= '0;
            wr_addr_reg <= '0;
         end else if (accept) begin
            if (err_sel == 2'd0) begin
               wr_en_reg   <= 1'b1;
               wr_addr_reg <= ptr_reg;
               wr_data_reg <= enc_word;
               ptr_reg     <= ptr_reg + 1'b1;
               count_reg   <= count_reg + 1'b1;
            end else begin
               err_valid_reg <= 1'b1;
               err_code_reg  <= err_sel;
            end
         end
      end
   end

   assign wr_en     = wr_en_reg;
   assign wr_addr   = wr_addr_reg;
   assign wr_data   = wr_data_reg;
   assign err_valid = err_valid_reg;
   assign err_code  = err_code_reg;
   assign count     = count_reg;

endmodule

// File: tb/tb_instr_assembler.sv
// Bench for instr_assembler: directed table, hand-written corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_instr_assembler;

   localparam int ADDR_W = 2;
   localparam int CAP    = 1 << ADDR_W;

   logic clk = 1'b0;
   logic reset, clear;
   always #5 clk = ~clk;

   instr_assembler_if bus();

   logic              wr_en, err_valid, full;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [1:0]        err_code;
   logic [ADDR_W:0]   count;

   instr_assembler #(.ADDR_W(ADDR_W), .SIZE(32)) dut (
      .clk(clk), .reset(reset), .clear(clear), .req(bus),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .err_valid(err_valid), .err_code(err_code), .count(count), .full(full)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state
   int          m_cnt;
   bit          m_full;
   bit          m_wen, m_ev;
   logic [1:0]  m_code;
   logic [31:0] m_addr;
   logic [31:0] m_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Error code from numeric ranges of each format
   function automatic logic [1:0] ref_code(input logic [2:0] src, input logic [31:0] imm);
      longint s, u;
      bit bad;
      s = longint'($signed(imm));
      u = longint'(imm);
      if (src == 3'd7) return 2'd3;
      if ((src == 3'd1 || src == 3'd3) && (u % 2 == 1)) return 2'd2;
      case (src)
         3'd0:        bad = (u % 4096) != 0;
         3'd1:        bad = (s < -(64'sd1 << 20)) || (s >= (64'sd1 << 20));
         3'd2, 3'd4:  bad = (s < -2048) || (s > 2047);
         3'd3:        bad = (s < -4096) || (s > 4095);
         3'd5:        bad = u > 31;
         default:     bad = u > 4095;
      endcase
      return bad ? 2'd1 : 2'd0;
   endfunction

   function automatic logic [31:0] bits(input logic [31:0] v, input int lo, input int n);
      return (v >> lo) & ((32'd1 << n) - 1);
   endfunction

   // Encoded word via shift-and-mask arithmetic
   function automatic logic [31:0] ref_enc(input logic [2:0] src, input logic [31:0] imm,
         input logic [6:0] op, input logic [4:0] rdv, input logic [4:0] r1,
         input logic [4:0] r2, input logic [2:0] f3, input logic [6:0] f7);
      logic [31:0] w;
      w = 32'(op);
      case (src)
         3'd0: w += (imm & 32'hFFFFF000) + (32'(rdv) << 7);
         3'd1: w += (bits(imm,20,1) << 31) + (bits(imm,1,10) << 21) + (bits(imm,11,1) << 20)
                  + (bits(imm,12,8) << 12) + (32'(rdv) << 7);
         3'd2: w += (bits(imm,5,7) << 25) + (32'(r2) << 20) + (32'(r1) << 15)
                  + (32'(f3) << 12) + (bits(imm,0,5) << 7);
         3'd3: w += (bits(imm,12,1) << 31) + (bits(imm,5,6) << 25) + (32'(r2) << 20)
                  + (32'(r1) << 15) + (32'(f3) << 12) + (bits(imm,1,4) << 8)
                  + (bits(imm,11,1) << 7);
         3'd5: w += (32'(f7) << 25) + (bits(imm,0,5) << 20) + (32'(r1) << 15)
                  + (32'(f3) << 12) + (32'(rdv) << 7);
         default: w += (bits(imm,0,12) << 20) + (32'(r1) << 15) + (32'(f3) << 12)
                  + (32'(rdv) << 7);
      endcase
      return w;
   endfunction

   // One clock cycle: drive, check in_ready, clock, update model, check outputs
   task automatic cycle(input bit rst, input bit clr, input bit v, input logic [2:0] src,
         input logic [31:0] imm, input logic [6:0] op, input logic [4:0] rdv,
         input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
         input logic [6:0] f7);
      bit rdy;
      logic [1:0] c;
      reset = rst; clear = clr; bus.in_valid = v;
      bus.imm_src = src; bus.imm_value = imm; bus.opcode = op; bus.rd = rdv;
      bus.rs1 = r1; bus.rs2 = r2; bus.funct3 = f3; bus.funct7 = f7;
      #1;
      rdy = !rst && !clr && !m_full;
      chk("in_ready", bus.in_ready, rdy);
      @(posedge clk);
      m_wen = 0; m_ev = 0;
      if (rst) begin
         m_cnt = 0; m_full = 0; m_code = 0; m_addr = 0; m_data = 0;
      end else if (clr) begin
         m_cnt = 0; m_full = 0; m_addr = 0;
      end else if (v && rdy) begin
         c = ref_code(src, imm);
         if (c == 0) begin
            m_wen = 1;
            m_addr = m_cnt % CAP;
            m_data = ref_enc(src, imm, op, rdv, r1, r2, f3, f7);
            m_cnt++;
            if (m_cnt == CAP) m_full = 1;
         end else begin
            m_ev = 1;
            m_code = c;
         end
      end
      #1;
      chk("wr_en", wr_en, m_wen);
      chk("err_valid", err_valid, m_ev);
      chk("err_code", err_code, m_code);
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_data", wr_data, m_data);
      chk("count", count, m_cnt);
      chk("full", full, m_full);
      $display("cyc rst=%0b clr=%0b v=%0b src=%0d imm=%h -> wr_en=%0b addr=%0d data=%h err=%0b/%0d cnt=%0d full=%0b",
               rst, clr, v, src, imm, wr_en, wr_addr, wr_data, err_valid, err_code, count, full);
   endtask

   typedef struct {
      logic [2:0]  src;
      logic [31:0] imm;
      logic [6:0]  op;
      logic [4:0]  rdv, r1, r2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      bit          wen;
      logic [31:0] data;
      logic [1:0]  code;
   } vec_t;

   vec_t tbl[7];
   logic [31:0] edges[16];

   initial begin
      tbl[0] = '{3'd0, 32'h12345000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 1, 32'h123452B7, 2'd0};
      tbl[1] = '{3'd3, 32'hFFFFFFFC, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 1, 32'hFE208EE3, 2'd0};
      tbl[2] = '{3'd4, 32'hFFFFFFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 1, 32'hFFF00093, 2'd0};
      tbl[3] = '{3'd1, 32'h00000003, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 0, 32'h0, 2'd2};
      tbl[4] = '{3'd4, 32'h00000800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 0, 32'h0, 2'd1};
      tbl[5] = '{3'd7, 32'h00000003, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 0, 32'h0, 2'd3};
      tbl[6] = '{3'd5, 32'h00000005, 7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 1, 32'h40525193, 2'd0};

      edges = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4095, 32'd4096,
                32'hFFFFF000, 32'hFFFFEFFF, 32'd31, 32'd32, 32'h000FFFFE, 32'h00100000,
                32'hFFF00000, 32'hFFEFFFFE, 32'h12345000, 32'h12345001};

      m_cnt = 0; m_full = 0; m_code = 0; m_addr = 0; m_data = 0;

      // Reset state
      cycle(1, 0, 0, 3'd0, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0);
      cycle(1, 0, 1, 3'd0, 32'h0, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0);

      // Directed table: back-to-back accepts, four writes fill the memory
      for (int i = 0; i < 7; i++) begin
         cycle(0, 0, 1, tbl[i].src, tbl[i].imm, tbl[i].op, tbl[i].rdv, tbl[i].r1,
               tbl[i].r2, tbl[i].f3, tbl[i].f7);
         chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].wen);
         chk($sformatf("tbl%0d_err_valid", i), err_valid, !tbl[i].wen);
         if (tbl[i].wen)
            chk($sformatf("tbl%0d_data", i), wr_data, tbl[i].data);
         else
            chk($sformatf("tbl%0d_code", i), err_code, tbl[i].code);
      end
      chk("last_slot_ready", bus.in_ready, 0);
      chk("full_after_4", full, 1);
      chk("count_after_4", count, 4);
      chk("last_addr", wr_addr, 3);

      // Fifth instruction while full is ignored
      cycle(0, 0, 1, 3'd0, 32'h00001000, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'h0);
      chk("fifth_no_write", wr_en, 0);

      // Clear with in_valid high: not accepted, pointer restarts
      cycle(0, 1, 1, 3'd0, 32'h00002000, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'h0);
      chk("clear_count", count, 0);
      chk("clear_full", full, 0);
      chk("clear_no_write", wr_en, 0);
      chk("clear_keeps_code", err_code, 2'd3);
      clear = 1'b0;
      #1;
      chk("ready_after_clear", bus.in_ready, 1);
      cycle(0, 0, 1, 3'd0, 32'h00003000, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'h0);
      chk("post_clear_addr", wr_addr, 0);
      chk("post_clear_data", wr_data, 32'h000033B7);

      // Reset right after an accept
      cycle(0, 0, 1, 3'd0, 32'h00004000, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0);
      cycle(1, 0, 0, 3'd0, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_data", wr_data, 0);
      chk("rst_count", count, 0);

      // Randomized traffic against the reference model
      for (int n = 0; n < 600; n++) begin
         logic [31:0] imm;
         int sel;
         sel = $urandom_range(0, 4);
         case (sel)
            0: imm = $urandom;
            1: imm = 32'($signed($urandom_range(0, 80)) - 40);
            2: imm = edges[$urandom_range(0, 15)];
            3: imm = $urandom << 12;
            default: imm = $urandom_range(0, 8191);
         endcase
         cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), imm,
               7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               3'($urandom), 7'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
